// File: rtl/atm_session_ctrl.sv
// ATM session FSM: card insert, PIN check, menu, one valid/ready request per operation, response display.
// Latency: txn_valid rises the cycle after the accepting key strobe; payload is held while txn_ready is low.
// Backpressure: keys are ignored in ISSUE/WAIT. Optional ATM_TIMEOUT_EN adds an inactivity eject.
module atm_session_ctrl #(
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       card_valid,
  input  logic [3:0] card_acct,
  input  logic       key_valid,
  input  logic [9:0] key_data,
  input  logic [7:0] pin_ref,
  output logic [3:0] acct_q,
  output logic       txn_valid,
  input  logic       txn_ready,
  output logic [1:0] txn_sel,
  output logic [3:0] txn_dest,
  output logic [9:0] txn_amt,
  input  logic       rsp_valid,
  input  logic [1:0] rsp_result,
  input  logic [9:0] rsp_inventory,
  output logic [1:0] disp_result,
  output logic [9:0] disp_inventory,
  output logic       card_eject,
  output logic       card_retain,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, PIN, MENU, DEST, AMOUNT, ISSUE, WAIT, EJECT
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] tries;
  logic       card_gone;
  logic       pin_bad, retain_set, clr_disp, ld_sel, ld_dest, ld_amt, ld_rsp;

`ifdef ATM_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        timed;
  assign timed = (state == PIN) || (state == MENU) || (state == DEST) || (state == AMOUNT);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pin_bad    = 1'b0;
    retain_set = 1'b0;
    clr_disp   = 1'b0;
    ld_sel     = 1'b0;
    ld_dest    = 1'b0;
    ld_amt     = 1'b0;
    ld_rsp     = 1'b0;
    case (state)
      IDLE: if (card_valid) state_nxt = PIN;
      PIN: begin
        if (!card_valid) state_nxt = IDLE;
        else if (key_valid) begin
          if (key_data[7:0] == pin_ref) state_nxt = MENU;
          else begin
            pin_bad = 1'b1;
            if (({1'b0, tries} + 4'd1) >= 4'(MAX_TRIES)) begin
              retain_set = 1'b1;
              state_nxt  = IDLE;
            end
          end
        end
      end
      MENU: begin
        if (!card_valid) state_nxt = IDLE;
        else if (key_valid) begin
          ld_sel = 1'b1;
          case (key_data[1:0])
            2'b00:   state_nxt = ISSUE;
            2'b01:   state_nxt = AMOUNT;
            2'b10:   state_nxt = DEST;
            default: state_nxt = EJECT;
          endcase
        end
      end
      DEST: begin
        if (!card_valid) state_nxt = IDLE;
        else if (key_valid) begin
          if (key_data[3:0] == acct_q) begin
            clr_disp  = 1'b1;
            state_nxt = MENU;
          end else begin
            ld_dest   = 1'b1;
            state_nxt = AMOUNT;
          end
        end
      end
      AMOUNT: begin
        if (!card_valid) state_nxt = IDLE;
        else if (key_valid) begin
          if (key_data == 10'd0) begin
            clr_disp  = 1'b1;
            state_nxt = MENU;
          end else begin
            ld_amt    = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: if (txn_ready) state_nxt = WAIT;
      WAIT: begin
        if (rsp_valid) begin
          ld_rsp    = 1'b1;
          // A card pulled mid-transaction ends the session once the response lands.
          state_nxt = (card_gone || !card_valid) ? IDLE : MENU;
        end
      end
      EJECT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef ATM_TIMEOUT_EN
    if (timed && card_valid && !key_valid && (state_nxt == state) &&
        (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)))
      state_nxt = EJECT;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acct_q         <= '0;
      tries          <= '0;
      card_gone      <= 1'b0;
      txn_sel        <= '0;
      txn_dest       <= '0;
      txn_amt        <= '0;
      disp_result    <= '0;
      disp_inventory <= '0;
      card_retain    <= 1'b0;
    end else begin
      card_retain <= retain_set;
      if (state == IDLE && card_valid) begin
        acct_q <= card_acct;
        tries  <= '0;
      end else if (pin_bad) begin
        tries <= tries + 3'd1;
      end
      if (state == IDLE) card_gone <= 1'b0;
      else if ((state == ISSUE || state == WAIT) && !card_valid) card_gone <= 1'b1;
      if (ld_sel) begin
        txn_sel  <= key_data[1:0];
        txn_dest <= acct_q;
        txn_amt  <= '0;
      end
      if (ld_dest) txn_dest <= key_data[3:0];
      if (ld_amt)  txn_amt  <= key_data;
      if (clr_disp) disp_result <= 2'b00;
      else if (ld_rsp) begin
        disp_result    <= rsp_result;
        disp_inventory <= rsp_inventory;
      end
    end
  end

`ifdef ATM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || !timed || key_valid || (state_nxt != state)) tmo_cnt <= '0;
    else                                                       tmo_cnt <= tmo_cnt + 32'd1;
  end
`endif

  assign txn_valid  = (state == ISSUE);
  assign card_eject = (state == EJECT);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: randomized sessions checked against an account/PIN store and expected request payloads.
module tb_atm_session_ctrl;
  localparam int MAX_TRIES = 3;

  logic       clk = 1'b0;
  logic       rst_n, card_valid, key_valid, txn_ready, rsp_valid;
  logic [3:0] card_acct, acct_q, txn_dest;
  logic [9:0] key_data, txn_amt, rsp_inventory, disp_inventory;
  logic [7:0] pin_ref;
  logic [1:0] txn_sel, rsp_result, disp_result;
  logic       txn_valid, card_eject, card_retain, busy;

  logic [7:0]  pin_store [16];
  int          errors = 0, checks = 0;
  int          n_eject = 0, n_retain = 0, n_txn = 0;
  logic [15:0] last_txn = '0;

  always #5 clk = ~clk;
  assign pin_ref = pin_store[acct_q];

  atm_session_ctrl #(.MAX_TRIES(MAX_TRIES), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .rst_n(rst_n), .card_valid(card_valid), .card_acct(card_acct),
    .key_valid(key_valid), .key_data(key_data), .pin_ref(pin_ref), .acct_q(acct_q),
    .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_sel(txn_sel), .txn_dest(txn_dest),
    .txn_amt(txn_amt), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_inventory(rsp_inventory), .disp_result(disp_result), .disp_inventory(disp_inventory),
    .card_eject(card_eject), .card_retain(card_retain), .busy(busy));

  // Pulse and handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (card_eject)  n_eject++;
    if (card_retain) n_retain++;
    if (txn_valid && txn_ready) begin
      n_txn++;
      last_txn = {txn_sel, txn_dest, txn_amt};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [9:0] d);
    key_valid = 1'b1;
    key_data  = d;
    tick();
    key_valid = 1'b0;
    key_data  = 10'($urandom);
  endtask

  task automatic start_session(input logic [3:0] a);
    card_valid = 1'b1;
    card_acct  = a;
    tick();
    press({2'b00, pin_store[a]});
  endtask

  task automatic eject_card(output logic seen);
    press(10'd3);
    seen       = card_eject;
    card_valid = 1'b0;
    tick();
  endtask

  // Drives a request from ISSUE through its response; stray keys are thrown in to show they are ignored.
  task automatic run_txn(input int delay, input logic [1:0] res, input logic [9:0] inv);
    for (int i = 0; i < delay; i++) begin
      txn_ready = 1'b0;
      key_valid = 1'($urandom);
      key_data  = 10'($urandom);
      tick();
    end
    key_valid = 1'b0;
    txn_ready = 1'b1;
    tick();
    txn_ready = 1'b0;
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
      key_valid = 1'($urandom);
      tick();
    end
    key_valid     = 1'b0;
    rsp_valid     = 1'b1;
    rsp_result    = res;
    rsp_inventory = inv;
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    card_valid = 1'b1; card_acct = 4'($urandom);
    tick(); tick();
    checks++; if (acct_q !== 4'd0)         begin errors++; $display("FAIL reset acct_q got %0d want 0", acct_q); end
    checks++; if (txn_valid !== 1'b0)      begin errors++; $display("FAIL reset txn_valid got %0b want 0", txn_valid); end
    checks++; if (txn_sel !== 2'd0)        begin errors++; $display("FAIL reset txn_sel got %0d want 0", txn_sel); end
    checks++; if (txn_dest !== 4'd0)       begin errors++; $display("FAIL reset txn_dest got %0d want 0", txn_dest); end
    checks++; if (txn_amt !== 10'd0)       begin errors++; $display("FAIL reset txn_amt got %0d want 0", txn_amt); end
    checks++; if (disp_result !== 2'd0)    begin errors++; $display("FAIL reset disp_result got %0d want 0", disp_result); end
    checks++; if (disp_inventory !== 10'd0) begin errors++; $display("FAIL reset disp_inventory got %0d want 0", disp_inventory); end
    checks++; if (card_eject !== 1'b0)     begin errors++; $display("FAIL reset card_eject got %0b want 0", card_eject); end
    checks++; if (card_retain !== 1'b0)    begin errors++; $display("FAIL reset card_retain got %0b want 0", card_retain); end
    checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL reset busy got %0b want 0", busy); end
    card_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_balance();
    logic [9:0] inv;
    logic       seen;
    int t0, e0;
    inv = 10'd200;
    t0 = n_txn; e0 = n_eject;
    start_session(4'd3);
    checks++; if (acct_q !== 4'd3) begin errors++; $display("FAIL balance acct_q got %0d want 3", acct_q); end
    press(10'd0);
    checks++; if (txn_valid !== 1'b1) begin errors++; $display("FAIL balance latency txn_valid got %0b want 1", txn_valid); end
    checks++; if ({txn_sel, txn_dest, txn_amt} !== {2'd0, 4'd3, 10'd0})
      begin errors++; $display("FAIL balance payload got %h want %h", {txn_sel, txn_dest, txn_amt}, {2'd0, 4'd3, 10'd0}); end
    run_txn($urandom_range(0, 3), 2'b01, inv);
    checks++; if (n_txn !== t0 + 1) begin errors++; $display("FAIL balance txn count got %0d want %0d", n_txn, t0 + 1); end
    checks++; if (disp_result !== 2'b01) begin errors++; $display("FAIL balance disp_result got %0d want 1", disp_result); end
    checks++; if (disp_inventory !== inv) begin errors++; $display("FAIL balance disp_inventory got %0d want %0d", disp_inventory, inv); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL balance busy in menu got %0b want 1", busy); end
    eject_card(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL balance eject pulse got %0b want 1", seen); end
    checks++; if (busy !== 1'b0 || card_eject !== 1'b0)
      begin errors++; $display("FAIL balance idle busy/eject got %0b%0b want 00", busy, card_eject); end
    checks++; if (n_eject !== e0 + 1) begin errors++; $display("FAIL balance eject count got %0d want %0d", n_eject, e0 + 1); end
  endtask

  task automatic test_retain();
    logic [3:0] a;
    logic       seen;
    int t0, r0;
    a = 4'($urandom);
    // Partial failures then the right PIN still reach the menu.
    card_valid = 1'b1; card_acct = a; tick();
    for (int i = 0; i < MAX_TRIES - 1; i++) press({2'b00, pin_store[a] ^ 8'($urandom_range(1, 255))});
    press({2'b00, pin_store[a]});
    press(10'd0);
    checks++; if (txn_valid !== 1'b1) begin errors++; $display("FAIL retain late-correct pin txn_valid got %0b want 1", txn_valid); end
    run_txn(0, 2'b01, 10'($urandom));
    eject_card(seen);
    t0 = n_txn; r0 = n_retain;
    card_valid = 1'b1; card_acct = a; tick();
    for (int i = 0; i < MAX_TRIES; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL retain busy before try %0d got %0b want 1", i, busy); end
      press({2'b00, pin_store[a] ^ 8'($urandom_range(1, 255))});
    end
    checks++; if (card_retain !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL retain pulse/busy got %0b%0b want 10", card_retain, busy); end
    card_valid = 1'b0;
    tick();
    checks++; if (card_retain !== 1'b0) begin errors++; $display("FAIL retain width got %0b want 0", card_retain); end
    checks++; if (n_retain !== r0 + 1) begin errors++; $display("FAIL retain count got %0d want %0d", n_retain, r0 + 1); end
    checks++; if (n_txn !== t0) begin errors++; $display("FAIL retain txn count got %0d want %0d", n_txn, t0); end
  endtask

  task automatic test_transfer_hold();
    logic [3:0] a, d;
    logic [9:0] amt, inv;
    logic [1:0] res;
    logic       seen;
    int t0;
    a = 4'($urandom); d = 4'd5; amt = 10'd100;
    if (a == d) a = 4'd9;
    inv = 10'($urandom); res = 2'($urandom_range(1, 3));
    t0 = n_txn;
    start_session(a);
    press(10'd2); press({6'd0, d}); press(amt);
    for (int i = 0; i < 4; i++) begin
      txn_ready = 1'b0;
      checks++; if (txn_valid !== 1'b1) begin errors++; $display("FAIL hold txn_valid cycle %0d got %0b want 1", i, txn_valid); end
      checks++; if ({txn_sel, txn_dest, txn_amt} !== {2'd2, d, amt})
        begin errors++; $display("FAIL hold payload cycle %0d got %h want %h", i, {txn_sel, txn_dest, txn_amt}, {2'd2, d, amt}); end
      key_valid = 1'b1; key_data = 10'($urandom);
      tick();
      key_valid = 1'b0;
    end
    checks++; if (n_txn !== t0) begin errors++; $display("FAIL hold early accept count got %0d want %0d", n_txn, t0); end
    run_txn(0, res, inv);
    checks++; if (n_txn !== t0 + 1 || last_txn !== {2'd2, d, amt})
      begin errors++; $display("FAIL hold accepted got %0d/%h want %0d/%h", n_txn, last_txn, t0 + 1, {2'd2, d, amt}); end
    checks++; if (disp_result !== res || disp_inventory !== inv)
      begin errors++; $display("FAIL hold display got %0d/%0d want %0d/%0d", disp_result, disp_inventory, res, inv); end
    press(10'd2); press({6'd0, a});
    checks++; if (disp_result !== 2'd0 || txn_valid !== 1'b0)
      begin errors++; $display("FAIL self-dest result/valid got %0d/%0b want 0/0", disp_result, txn_valid); end
    eject_card(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL self-dest back-to-menu eject got %0b want 1", seen); end
  endtask

  task automatic test_zero_amount();
    logic [3:0] a;
    logic       seen;
    int t0, e0;
    a = 4'($urandom);
    start_session(a);
    press(10'd0);
    run_txn(1, 2'($urandom_range(1, 3)), 10'($urandom));
    t0 = n_txn; e0 = n_eject;
    press(10'd1); press(10'd0);
    checks++; if (disp_result !== 2'd0) begin errors++; $display("FAIL zero amount disp_result got %0d want 0", disp_result); end
    checks++; if (txn_valid !== 1'b0 || n_txn !== t0)
      begin errors++; $display("FAIL zero amount issued got %0b/%0d want 0/%0d", txn_valid, n_txn, t0); end
    eject_card(seen);
    checks++; if (seen !== 1'b1 || n_eject !== e0 + 1 || busy !== 1'b0)
      begin errors++; $display("FAIL select-11 eject got %0b/%0d/%0b want 1/%0d/0", seen, n_eject, busy, e0 + 1); end
  endtask

  task automatic test_card_pull();
    logic [9:0] inv;
    logic [1:0] res;
    int e0;
    inv = 10'($urandom); res = 2'($urandom_range(0, 3));
    e0 = n_eject;
    start_session(4'($urandom));
    press(10'd0);
    txn_ready = 1'b1; tick(); txn_ready = 1'b0;
    card_valid = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pull waiting busy got %0b want 1", busy); end
    rsp_valid = 1'b1; rsp_result = res; rsp_inventory = inv;
    tick();
    rsp_valid = 1'b0;
    checks++; if (disp_result !== res || disp_inventory !== inv)
      begin errors++; $display("FAIL pull display got %0d/%0d want %0d/%0d", disp_result, disp_inventory, res, inv); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pull idle busy got %0b want 0", busy); end
    start_session(4'($urandom));
    card_valid = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pull in menu busy got %0b want 0", busy); end
    checks++; if (n_eject !== e0) begin errors++; $display("FAIL pull eject count got %0d want %0d", n_eject, e0); end
  endtask

  task automatic test_reset_mid_issue();
    int t0;
    start_session(4'($urandom));
    press(10'd0);
    t0 = n_txn;
    txn_ready = 1'b0;
    checks++; if (txn_valid !== 1'b1) begin errors++; $display("FAIL mid-reset pre txn_valid got %0b want 1", txn_valid); end
    rst_n = 1'b0;
    tick();
    checks++; if (txn_valid !== 1'b0 || busy !== 1'b0 || acct_q !== 4'd0)
      begin errors++; $display("FAIL mid-reset valid/busy/acct got %0b/%0b/%0d want 0/0/0", txn_valid, busy, acct_q); end
    card_valid = 1'b0;
    rst_n = 1'b1;
    rsp_valid = 1'b1; rsp_result = 2'($urandom_range(1, 3)); rsp_inventory = 10'($urandom_range(1, 1023));
    tick();
    rsp_valid = 1'b0;
    checks++; if (disp_result !== 2'd0 || disp_inventory !== 10'd0 || n_txn !== t0)
      begin errors++; $display("FAIL mid-reset stray rsp got %0d/%0d/%0d want 0/0/%0d", disp_result, disp_inventory, n_txn, t0); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  a, d;
    logic [9:0]  amt, inv;
    logic [1:0]  sel, res;
    logic [15:0] exp;
    logic        seen;
    int t0;
    a = 4'($urandom);
    start_session(a);
    for (int i = 0; i < 10; i++) begin
      sel = 2'($urandom_range(0, 2));
      d   = a ^ 4'($urandom_range(1, 15));
      amt = 10'($urandom_range(1, 1023));
      inv = 10'($urandom); res = 2'($urandom);
      t0  = n_txn;
      press({8'd0, sel});
      case (sel)
        2'd0:    exp = {2'd0, a, 10'd0};
        2'd1:    begin press(amt); exp = {2'd1, a, amt}; end
        default: begin press({6'd0, d}); press(amt); exp = {2'd2, d, amt}; end
      endcase
      checks++; if (txn_valid !== 1'b1 || {txn_sel, txn_dest, txn_amt} !== exp)
        begin errors++; $display("FAIL b2b %0d issue got %0b/%h want 1/%h", i, txn_valid, {txn_sel, txn_dest, txn_amt}, exp); end
      run_txn($urandom_range(0, 3), res, inv);
      checks++; if (n_txn !== t0 + 1 || last_txn !== exp || disp_result !== res || disp_inventory !== inv)
        begin errors++; $display("FAIL b2b %0d result got %0d/%h/%0d/%0d want %0d/%h/%0d/%0d",
                                  i, n_txn, last_txn, disp_result, disp_inventory, t0 + 1, exp, res, inv); end
    end
    eject_card(seen);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) pin_store[i] = 8'($urandom);
    rst_n = 1'b0; card_valid = 1'b0; card_acct = '0; key_valid = 1'b0; key_data = '0;
    txn_ready = 1'b0; rsp_valid = 1'b0; rsp_result = '0; rsp_inventory = '0;
    test_reset();
    test_balance();
    test_retain();
    test_transfer_hold();
    test_zero_amount();
    test_card_pull();
    test_reset_mid_issue();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
